wbm: RTL and testbench

- Write-back stage; sits directly downstream of the execute stage (exm) and consumes its result handshake.
- Buffers completed results in a small FIFO and retires one per cycle into the register-file write port.
- Publishes a busy mask of pending destination registers for decode hazard detection.
- Maintains the 64-bit retired-instruction counter.

---
 rtl/wbm.sv | 115 +++++++++++
 tb/tb_wbm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wbm.sv
// Write-back stage: buffers execute results in a small FIFO, retires one per
// cycle into the register-file write port, and tracks pending destinations.
module wbm #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic        result_write_i,
  input  logic [4:0]  result_addr_i,
  input  logic [31:0] result_i,
  input  logic        halt_i,
  output logic        reg_write_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] busy_mask_o,
  output logic [63:0] instret_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]      rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         reg_waddr_q, reg_waddr_d;
  logic [31:0]        reg_wdata_q, reg_wdata_d;
  logic [63:0]        instret_q, instret_d;
  logic               push, pop;
  entry_t             head;
  logic [31:0]        busy;
  logic [AW-1:0]      off;

  // Ready comes from the registered count only, so a same-cycle pop never
  // frees a slot for the incoming result.
  assign input_ready_o = (cnt_q != (AW+1)'(DEPTH));

  always_comb begin
    push        = input_valid_i && input_ready_o;
    pop         = (cnt_q != '0) && !halt_i;
    head        = mem_q[rptr_q];
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    reg_write_d = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    instret_d   = instret_q;
    if (push) begin
      mem_d[wptr_q] = '{wr: result_write_i, addr: result_addr_i, data: result_i};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d      = rptr_q + 1'b1;
      reg_write_d = head.wr && (head.addr != 5'd0);
      reg_waddr_d = head.addr;
      reg_wdata_d = head.data;
      instret_d   = instret_q + 64'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q       <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
      cnt_q       <= '0;
      reg_write_q <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      instret_q   <= '0;
    end else begin
      mem_q       <= mem_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      reg_write_q <= reg_write_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      instret_q   <= instret_d;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    busy = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr_q;
      if (({1'b0, off} < cnt_q) && mem_q[i].wr)
        busy = busy | (32'd1 << mem_q[i].addr);
    end
    if (reg_write_q)
      busy = busy | (32'd1 << reg_waddr_q);
    busy[0] = 1'b0;
  end

  assign busy_mask_o = busy;
  assign reg_write_o = reg_write_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign instret_o   = instret_q;
endmodule

// File: tb/tb_wbm.sv
// Directed bench for wbm: a queue model of the FIFO predicts acceptance,
// retirement order and instret; busy mask and reset are checked directly.
module tb_wbm;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        input_ready_o;
  logic        input_valid_i = 1'b0;
  logic        result_write_i = 1'b0;
  logic [4:0]  result_addr_i = '0;
  logic [31:0] result_i = '0;
  logic        halt_i = 1'b0;
  logic        reg_write_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] busy_mask_o;
  logic [63:0] instret_o;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_ret = 64'd0;

  wbm #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .input_ready_o (input_ready_o),
    .input_valid_i (input_valid_i),
    .result_write_i(result_write_i),
    .result_addr_i (result_addr_i),
    .result_i      (result_i),
    .halt_i        (halt_i),
    .reg_write_o   (reg_write_o),
    .reg_waddr_o   (reg_waddr_o),
    .reg_wdata_o   (reg_wdata_o),
    .busy_mask_o   (busy_mask_o),
    .instret_o     (instret_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    input_valid_i  = v;
    result_write_i = w;
    result_addr_i  = a;
    result_i       = d;
  endtask

  // One clock: predict accept/pop from the model, then check the retire port.
  task automatic tick(input string tag);
    logic exp_acc, exp_pop;
    exp_t e, n;
    exp_acc = input_valid_i && (sb.size() != DEPTH);
    exp_pop = (sb.size() != 0) && !halt_i;
    chk({tag, ".ready"}, 64'(input_ready_o), 64'(sb.size() != DEPTH));
    n.w = result_write_i && (result_addr_i != 5'd0);
    n.a = result_addr_i;
    n.d = result_i;
    @(posedge clk);
    #1;
    if (exp_pop) begin
      e = sb.pop_front();
      exp_ret = exp_ret + 64'd1;
      chk({tag, ".wr"},    64'(reg_write_o), 64'(e.w));
      chk({tag, ".waddr"}, 64'(reg_waddr_o), 64'(e.a));
      chk({tag, ".wdata"}, 64'(reg_wdata_o), 64'(e.d));
    end else begin
      chk({tag, ".idle_wr"}, 64'(reg_write_o), 64'd0);
    end
    if (exp_acc) sb.push_back(n);
    chk({tag, ".instret"}, instret_o, exp_ret);
  endtask

  initial begin
    #1;
    chk("rst.wr",      64'(reg_write_o), 64'd0);
    chk("rst.waddr",   64'(reg_waddr_o), 64'd0);
    chk("rst.wdata",   64'(reg_wdata_o), 64'd0);
    chk("rst.busy",    64'(busy_mask_o), 64'd0);
    chk("rst.instret", instret_o, 64'd0);
    #11 rst_i = 1'b1;
    @(negedge clk);
    chk("rst.ready", 64'(input_ready_o), 64'd1);

    // Single result: sits in FIFO one cycle, then in the retire register.
    drive(1, 1, 5'd5, 32'hDEADBEEF);
    tick("single.acc");
    drive(0, 0, 5'd0, 32'h0);
    chk("single.busy_fifo", 64'(busy_mask_o), 64'h20);
    tick("single.ret");
    chk("single.busy_ret", 64'(busy_mask_o), 64'h20);
    tick("single.idle");
    chk("single.busy_clr", 64'(busy_mask_o), 64'h0);

    // x0 write and a no-write result: popped and counted, never written.
    drive(1, 1, 5'd0, 32'h1);
    tick("x0.acc");
    chk("x0.busy", 64'(busy_mask_o), 64'h0);
    drive(1, 0, 5'd7, 32'h2);
    tick("nw.acc");
    drive(0, 0, 5'd0, 32'h0);
    chk("nw.busy", 64'(busy_mask_o), 64'h0);
    tick("nw.ret");
    chk("nw.busy2", 64'(busy_mask_o), 64'h0);
    chk("nw.instret", instret_o, 64'd3);
    tick("nw.idle");

    // Backpressure under halt, then full with a simultaneous pop.
    halt_i = 1'b1;
    drive(1, 1, 5'd1, 32'hA); tick("bp.a");
    drive(1, 1, 5'd2, 32'hB); tick("bp.b");
    drive(1, 1, 5'd3, 32'hC);
    chk("bp.full_ready", 64'(input_ready_o), 64'd0);
    tick("bp.c_blocked");
    chk("bp.hold_wr", 64'(reg_write_o), 64'd0);
    halt_i = 1'b0;
    tick("bp.pop_no_acc");
    chk("bp.a_data", 64'(reg_wdata_o), 64'hA);
    tick("bp.c_acc");
    drive(0, 0, 5'd0, 32'h0);
    chk("bp.b_data", 64'(reg_wdata_o), 64'hB);
    tick("bp.c_ret");
    chk("bp.c_data", 64'(reg_wdata_o), 64'hC);
    chk("bp.instret", instret_o, 64'd6);
    tick("bp.idle");

    // Busy mask across a staggered drain.
    halt_i = 1'b1;
    drive(1, 1, 5'd3, 32'h33); tick("bm.a3");
    drive(1, 1, 5'd9, 32'h99); tick("bm.a9");
    drive(0, 0, 5'd0, 32'h0);
    chk("bm.both", 64'(busy_mask_o), 64'h208);
    halt_i = 1'b0;
    tick("bm.r3");
    chk("bm.r3_mask", 64'(busy_mask_o), 64'h208);
    tick("bm.r9");
    chk("bm.r9_mask", 64'(busy_mask_o), 64'h200);
    tick("bm.idle");
    chk("bm.clr", 64'(busy_mask_o), 64'h0);

    // Async reset mid-cycle with two entries pending.
    halt_i = 1'b1;
    drive(1, 1, 5'd4, 32'h44); tick("ar.a");
    drive(1, 1, 5'd6, 32'h66); tick("ar.b");
    drive(0, 0, 5'd0, 32'h0);
    chk("ar.busy_pre", 64'(busy_mask_o), 64'h50);
    #3 rst_i = 1'b0;
    #1;
    chk("ar.wr",      64'(reg_write_o), 64'd0);
    chk("ar.wdata",   64'(reg_wdata_o), 64'd0);
    chk("ar.busy",    64'(busy_mask_o), 64'h0);
    chk("ar.instret", instret_o, 64'd0);
    chk("ar.ready",   64'(input_ready_o), 64'd1);
    sb.delete();
    exp_ret = 64'd0;
    halt_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    tick("ar.post1");
    tick("ar.post2");
    chk("ar.busy_post", 64'(busy_mask_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
